// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// A local command (valid/ready) becomes one APB SETUP/ACCESS transfer. The
// response, carrying read data, slave error and timeout status, is returned
// over a valid/ready channel. Wait states are bounded by TIMEOUT_CYCLES
// (0 = unbounded).
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    // command channel
    input  logic                  CmdVALID,
    output logic                  CmdREADY,
    input  logic [ADDR_WIDTH-1:0] CmdADDR,
    input  logic                  CmdWRITE,
    input  logic [DATA_WIDTH-1:0] CmdWDATA,
    // response channel
    output logic                  RspVALID,
    input  logic                  RspREADY,
    output logic [DATA_WIDTH-1:0] RspRDATA,
    output logic                  RspSLVERR,
    output logic                  RspTIMEOUT,
    // APB bus
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    // Wait counter is wide enough to hold TIMEOUT_CYCLES; at least one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_r;
    logic                  psel_r;
    logic                  penable_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic                  pwrite_r;
    logic [DATA_WIDTH-1:0] pwdata_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  rsp_slverr_r;
    logic                  rsp_timeout_r;
    logic [CNT_W-1:0]      wait_cnt_r;

    logic                  cmd_ready_s;
    logic                  cmd_hs_s;
    logic                  rsp_hs_s;

    // Accept a command only when idle and any held response is leaving this cycle.
    always_comb begin
        cmd_ready_s = 1'b0;
        if (!PRESET && (state_r == ST_IDLE) && (!rsp_valid_r || RspREADY)) begin
            cmd_ready_s = 1'b1;
        end else begin
            cmd_ready_s = 1'b0;
        end
        cmd_hs_s = CmdVALID && cmd_ready_s;
        rsp_hs_s = rsp_valid_r && RspREADY;
    end

    // Transfer sequencer: IDLE -> SETUP -> ACCESS, with response capture and hold.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r       <= ST_IDLE;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            paddr_r       <= {ADDR_WIDTH{1'b0}};
            pwrite_r      <= 1'b0;
            pwdata_r      <= {DATA_WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
            wait_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            // A consumed response drops valid; fields keep their values.
            if (rsp_hs_s) begin
                rsp_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (cmd_hs_s) begin
                        paddr_r   <= CmdADDR;
                        pwrite_r  <= CmdWRITE;
                        pwdata_r  <= CmdWDATA;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        state_r   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_r  <= 1'b1;
                    wait_cnt_r <= {CNT_W{1'b0}};
                    state_r    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        state_r       <= ST_IDLE;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= pwrite_r ? {DATA_WIDTH{1'b0}} : PRDATA;
                        rsp_slverr_r  <= PSLVERR;
                        rsp_timeout_r <= 1'b0;
                    end else if (TIMEOUT_EN && (wait_cnt_r == CNT_LIMIT)) begin
                        // Too many wait states: abandon the transfer with an error.
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        state_r       <= ST_IDLE;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
                        rsp_slverr_r  <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                    end else if (wait_cnt_r != CNT_MAX) begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

    assign CmdREADY   = cmd_ready_s;
    assign RspVALID   = rsp_valid_r;
    assign RspRDATA   = rsp_rdata_r;
    assign RspSLVERR  = rsp_slverr_r;
    assign RspTIMEOUT = rsp_timeout_r;
    assign PSELx      = psel_r;
    assign PENABLE    = penable_r;
    assign PADDR      = paddr_r;
    assign PWRITE     = pwrite_r;
    assign PWDATA     = pwdata_r;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: self-checking bench for apb_master.
// dut0 uses a 4-cycle wait-state limit, dut1 has the timeout disabled; both
// share the same stimulus. Expected responses come from a transaction-level
// model of the bus protocol.
module tb_apb_master;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic        rsp_ready;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    logic        cmd_ready,  rsp_valid,  rsp_slverr,  rsp_timeout,  psel,  penable,  pwrite;
    logic [31:0] rsp_rdata,  paddr,  pwdata;
    logic        cmd_ready1, rsp_valid1, rsp_slverr1, rsp_timeout1, psel1, penable1, pwrite1;
    logic [31:0] rsp_rdata1, paddr1, pwdata1;

    int errs;
    int checks;

    apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut0 (
        .PCLK(clk), .PRESET(rst),
        .CmdVALID(cmd_valid), .CmdREADY(cmd_ready), .CmdADDR(cmd_addr),
        .CmdWRITE(cmd_write), .CmdWDATA(cmd_wdata),
        .RspVALID(rsp_valid), .RspREADY(rsp_ready), .RspRDATA(rsp_rdata),
        .RspSLVERR(rsp_slverr), .RspTIMEOUT(rsp_timeout),
        .PSELx(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr)
    );

    apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut1 (
        .PCLK(clk), .PRESET(rst),
        .CmdVALID(cmd_valid), .CmdREADY(cmd_ready1), .CmdADDR(cmd_addr),
        .CmdWRITE(cmd_write), .CmdWDATA(cmd_wdata),
        .RspVALID(rsp_valid1), .RspREADY(rsp_ready), .RspRDATA(rsp_rdata1),
        .RspSLVERR(rsp_slverr1), .RspTIMEOUT(rsp_timeout1),
        .PSELx(psel1), .PENABLE(penable1), .PADDR(paddr1), .PWRITE(pwrite1),
        .PWDATA(pwdata1), .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transaction-level expectation for one transfer.
    typedef struct packed {
        int          cycles;   // ACCESS cycles until the bus is released
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
    } exp_t;

    function automatic exp_t model(input int limit, input int waits, input logic wr,
                                   input logic [31:0] rd, input logic err);
        exp_t e;
        if (limit != 0 && waits > limit) begin
            e.cycles = limit + 1;
            e.rdata  = 32'h0000_0000;
            e.slverr = 1'b1;
            e.tmo    = 1'b1;
        end else begin
            e.cycles = waits + 1;
            e.rdata  = wr ? 32'h0000_0000 : rd;
            e.slverr = err;
            e.tmo    = 1'b0;
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One full transfer on dut0; any held response is consumed in the accept cycle.
    task automatic do_xfer(input logic [31:0] a, input logic [31:0] d, input logic wr,
                           input int waits, input logic [31:0] rd, input logic err,
                           input int hold, input string tag);
        exp_t e;
        logic last;
        e = model(TMO, waits, wr, rd, err);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = wr; cmd_wdata = d; rsp_ready = 1'b1;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errs++; $display("FAIL %s accept: CmdREADY=%b expected 1", tag, cmd_ready);
        end

        @(negedge clk);
        checks++;
        if ({psel, penable, paddr, pwrite, pwdata, rsp_valid, cmd_ready} !==
            {1'b1, 1'b0, a, wr, d, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL %s setup: sel=%b en=%b addr=%h wr=%b wd=%h rv=%b cr=%b expected 1 0 %h %b %h 0 0",
                     tag, psel, penable, paddr, pwrite, pwdata, rsp_valid, cmd_ready, a, wr, d);
        end
        cmd_valid = 1'($urandom); cmd_addr = $urandom; cmd_write = 1'($urandom); cmd_wdata = $urandom;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);

        for (int k = 0; k < e.cycles; k++) begin
            @(negedge clk);
            checks++;
            if ({psel, penable, paddr, pwrite, pwdata} !== {1'b1, 1'b1, a, wr, d}) begin
                errs++;
                $display("FAIL %s access%0d: sel=%b en=%b addr=%h wr=%b wd=%h expected 1 1 %h %b %h",
                         tag, k, psel, penable, paddr, pwrite, pwdata, a, wr, d);
            end
            last = (k == e.cycles - 1);
            pready = last && !e.tmo;
            if (pready) begin
                prdata = rd; pslverr = err;
            end else begin
                prdata = $urandom; pslverr = 1'($urandom);
            end
            cmd_valid = 1'($urandom); cmd_addr = $urandom;
        end

        @(negedge clk);
        checks++;
        if ({psel, penable, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout} !==
            {1'b0, 1'b0, 1'b1, e.rdata, e.slverr, e.tmo}) begin
            errs++;
            $display("FAIL %s response: sel=%b en=%b rv=%b rd=%h err=%b tmo=%b expected 0 0 1 %h %b %b",
                     tag, psel, penable, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
                     e.rdata, e.slverr, e.tmo);
        end
        checks++;
        if ({paddr, pwrite, pwdata} !== {a, wr, d}) begin
            errs++;
            $display("FAIL %s bus_hold: addr=%h wr=%b wd=%h expected %h %b %h",
                     tag, paddr, pwrite, pwdata, a, wr, d);
        end
        cmd_valid = 1'b1; cmd_addr = $urandom; rsp_ready = 1'b0;
        pready = 1'($urandom); prdata = $urandom;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, cmd_ready, psel, rsp_rdata, rsp_slverr, rsp_timeout} !==
                {1'b1, 1'b0, 1'b0, e.rdata, e.slverr, e.tmo}) begin
                errs++;
                $display("FAIL %s rsp_hold%0d: rv=%b cr=%b sel=%b rd=%h err=%b tmo=%b expected 1 0 0 %h %b %b",
                         tag, h, rsp_valid, cmd_ready, psel, rsp_rdata, rsp_slverr, rsp_timeout,
                         e.rdata, e.slverr, e.tmo);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1; pready = 1'b1;
        cmd_addr = 32'h0000_00F0; cmd_write = 1'b1; cmd_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errs++; $display("FAIL reset cmd_ready: %b expected 0", cmd_ready);
        end
        checks++;
        if ((|{psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               psel1, penable1, pwrite1, paddr1, pwdata1, rsp_valid1, rsp_rdata1}) !== 1'b0) begin
            errs++;
            $display("FAIL reset outputs: sel=%b en=%b addr=%h wd=%h rv=%b rd=%h sel1=%b rv1=%b expected all 0",
                     psel, penable, paddr, pwdata, rsp_valid, rsp_rdata, psel1, rsp_valid1);
        end
        rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errs++; $display("FAIL reset release cmd_ready: %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        do_xfer(32'h0000_0004, 32'hDEAD_BEEF, 1'b1, 0, 32'h5A5A_5A5A, 1'b0, 0, "write");
    endtask

    task automatic test_read_wait();
        do_xfer(32'h0000_0008, 32'h0000_0000, 1'b0, 3, 32'h1234_5678, 1'b0, 0, "read_wait");
    endtask

    task automatic test_slverr();
        do_xfer(32'h0000_000C, 32'h0000_0000, 1'b0, 1, 32'hCAFE_0001, 1'b1, 0, "slverr");
    endtask

    task automatic test_timeout();
        do_xfer(32'h0000_0010, 32'h0000_0000, 1'b0, 10, 32'h7777_7777, 1'b0, 0, "timeout");
    endtask

    task automatic test_rsp_hold();
        do_xfer(32'h0000_0014, 32'h0BAD_F00D, 1'b1, 0, 32'h0, 1'b0, 5, "rsp_hold");
    endtask

    task automatic test_back_to_back();
        do_xfer(32'h0000_0018, 32'h1111_2222, 1'b1, 0, 32'h0, 1'b0, 0, "b2b_a");
        do_xfer(32'h0000_001C, 32'h0000_0000, 1'b0, 0, 32'h3333_4444, 1'b0, 0, "b2b_b");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            do_xfer($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 6)), $urandom,
                    1'($urandom), int'($urandom_range(0, 3)), "random");
        end
        @(negedge clk);
        rsp_ready = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, psel, cmd_ready} !== {1'b0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL drain: rv=%b sel=%b cr=%b expected 0 0 1", rsp_valid, psel, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h0000_0020; cmd_write = 1'b0; cmd_wdata = 32'h0;
        rsp_ready = 1'b1; pready = 1'b0;
        @(negedge clk);                     // SETUP
        cmd_valid = 1'b0;
        @(negedge clk);                     // ACCESS 1
        pready = 1'b0;
        @(negedge clk);                     // ACCESS 2
        checks++;
        if ({psel, penable} !== 2'b11) begin
            errs++; $display("FAIL reset_mid pre: sel=%b en=%b expected 1 1", psel, penable);
        end
        rst = 1'b1; pready = 1'b1; prdata = 32'h9999_9999; cmd_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({psel, penable, rsp_valid, paddr, cmd_ready} !== {1'b0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid: sel=%b en=%b rv=%b addr=%h cr=%b expected 0 0 0 0 0",
                     psel, penable, rsp_valid, paddr, cmd_ready);
        end
        rst = 1'b0; cmd_valid = 1'b0; pready = 1'b0;
        @(negedge clk);
        checks++;
        if ({psel, rsp_valid, cmd_ready} !== {1'b0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL reset_mid after: sel=%b rv=%b cr=%b expected 0 0 1", psel, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_no_timeout();
        exp_t e;
        int   bad;
        e = model(0, 100, 1'b0, 32'hA5A5_0F0F, 1'b0);
        bad = 0;
        do_reset();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h0000_0030; cmd_write = 1'b0; cmd_wdata = 32'h0;
        rsp_ready = 1'b1; pready = 1'b0;
        #1;
        checks++;
        if (cmd_ready1 !== 1'b1) begin
            errs++; $display("FAIL no_timeout accept: CmdREADY=%b expected 1", cmd_ready1);
        end
        @(negedge clk);                     // SETUP
        cmd_valid = 1'b0;
        for (int k = 0; k < e.cycles; k++) begin
            @(negedge clk);
            if ({psel1, penable1, paddr1} !== {1'b1, 1'b1, 32'h0000_0030}) bad++;
            pready = (k == e.cycles - 1);
            prdata = pready ? 32'hA5A5_0F0F : $urandom;
            pslverr = 1'b0;
        end
        checks++;
        if (bad !== 0) begin
            errs++; $display("FAIL no_timeout access: %0d bad ACCESS cycles expected 0", bad);
        end
        @(negedge clk);
        checks++;
        if ({psel1, rsp_valid1, rsp_rdata1, rsp_slverr1, rsp_timeout1} !==
            {1'b0, 1'b1, e.rdata, e.slverr, e.tmo}) begin
            errs++;
            $display("FAIL no_timeout response: sel=%b rv=%b rd=%h err=%b tmo=%b expected 0 1 %h %b %b",
                     psel1, rsp_valid1, rsp_rdata1, rsp_slverr1, rsp_timeout1, e.rdata, e.slverr, e.tmo);
        end
        pready = 1'b0;
        do_reset();
    endtask

    // Test sequence.
    initial begin
        errs = 0; checks = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_write = 1'b0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_rsp_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_no_timeout();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
